// File: rtl/unified_freelist_pkg.sv
// unified_freelist_pkg: shared rename parameters, physical register type and free list depth
package unified_freelist_pkg;
   localparam int PHYS_REGS            = 64;
   localparam int ARCH_REGS            = 32;
   localparam int DISPATCH_WIDTH       = 2;
   localparam int COMMIT_WIDTH         = 2;
   localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
   localparam int FREELIST_DEPTH       = PHYS_REGS - ARCH_REGS;
   localparam int FREELIST_CNT_W       = $clog2(FREELIST_DEPTH + 1);
   typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] preg_t;
endpackage

// File: rtl/unified_freelist_if.sv
// unified_freelist_if: allocate/free bundle; flush and commit_alloc_num exist only with FREELIST_CHECKPOINT_EN
interface unified_freelist_if import unified_freelist_pkg::*; #(
   parameter int ALLOC_WIDTH = DISPATCH_WIDTH,
   parameter int FREE_WIDTH  = COMMIT_WIDTH,
   parameter int PREG_W      = PHYS_REGS_ADDR_WIDTH,
   parameter int CNT_W       = FREELIST_CNT_W
);
   logic [ALLOC_WIDTH-1:0]             alloc_req;
   logic                               alloc_ready;
   logic [ALLOC_WIDTH-1:0][PREG_W-1:0] alloc_reg;
   logic [FREE_WIDTH-1:0]              free_en;
   logic [FREE_WIDTH-1:0][PREG_W-1:0]  free_reg;
   logic [CNT_W-1:0]                   free_count;
   logic                               overflow_err;
`ifdef FREELIST_CHECKPOINT_EN
   logic                                  flush;
   logic [$clog2(FREE_WIDTH+1)-1:0]       commit_alloc_num;
   modport master (output alloc_req, free_en, free_reg, flush, commit_alloc_num,
                   input alloc_ready, alloc_reg, free_count, overflow_err);
   modport slave  (input alloc_req, free_en, free_reg, flush, commit_alloc_num,
                   output alloc_ready, alloc_reg, free_count, overflow_err);
`else
   modport master (output alloc_req, free_en, free_reg,
                   input alloc_ready, alloc_reg, free_count, overflow_err);
   modport slave  (input alloc_req, free_en, free_reg,
                   output alloc_ready, alloc_reg, free_count, overflow_err);
`endif
endinterface

// File: rtl/unified_freelist_lane_prefix_count.sv
// lane_prefix_count: exclusive prefix popcount per lane plus total popcount
module lane_prefix_count #(
   parameter int N = 2,
   localparam int CW = $clog2(N + 1)
) (
   input  logic [N-1:0]         vec_i,
   output logic [N-1:0][CW-1:0] prefix_o,
   output logic [CW-1:0]        total_o
);
   logic [CW-1:0] acc;
   always_comb begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
         prefix_o[i] = acc;
         acc = acc + CW'(vec_i[i]);
      end
      total_o = acc;
   end
endmodule

// File: rtl/unified_freelist.sv
// unified_freelist: shared circular pool of free physical registers; FREELIST_CHECKPOINT_EN adds committed-head flush recovery
module unified_freelist import unified_freelist_pkg::*; #(
   parameter int PHYS_REGS   = unified_freelist_pkg::PHYS_REGS,
   parameter int ARCH_REGS   = unified_freelist_pkg::ARCH_REGS,
   parameter int ALLOC_WIDTH = DISPATCH_WIDTH,
   parameter int FREE_WIDTH  = COMMIT_WIDTH
) (
   input logic               clk,
   input logic               rst,
   unified_freelist_if.slave fl
);
   localparam int DEPTH  = PHYS_REGS - ARCH_REGS;
   localparam int PREG_W = $clog2(PHYS_REGS);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PTR_W  = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int AW     = $clog2(ALLOC_WIDTH + 1);
   localparam int FW     = $clog2(FREE_WIDTH + 1);

   logic [PREG_W-1:0]              entry_q [DEPTH];
   logic [PREG_W-1:0]              entry_d [DEPTH];
   logic [PTR_W-1:0]               head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]               count_q, count_d;
   logic                           ovf_q, ovf_d;
   logic [ALLOC_WIDTH-1:0][AW-1:0] a_pre;
   logic [AW-1:0]                  nreq;
   logic [FREE_WIDTH-1:0][FW-1:0]  f_pre;
   logic [FW-1:0]                  nfree;
   logic                           flush_w, fire;
   int                             nalloc, room, nacc;

   // modular pointer advance; DEPTH need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_add(int p, int k);
      return PTR_W'(p + k >= DEPTH ? p + k - DEPTH : p + k);
   endfunction

   lane_prefix_count #(.N(ALLOC_WIDTH)) u_alloc_pc (.vec_i(fl.alloc_req), .prefix_o(a_pre), .total_o(nreq));
   lane_prefix_count #(.N(FREE_WIDTH))  u_free_pc  (.vec_i(fl.free_en),   .prefix_o(f_pre), .total_o(nfree));

`ifdef FREELIST_CHECKPOINT_EN
   logic [PTR_W-1:0] chead_q, chead_d;
   logic [CNT_W-1:0] ccount_q, ccount_d;
   assign flush_w = fl.flush;
`else
   assign flush_w = 1'b0;
`endif

   // grants read pre-cycle state only, so a register freed now is visible next cycle
   always_comb begin
      fl.alloc_ready = int'(count_q) >= int'(nreq);
      for (int i = 0; i < ALLOC_WIDTH; i++)
         fl.alloc_reg[i] = entry_q[ptr_add(int'(head_q), int'(a_pre[i]))];
   end

   assign fire            = fl.alloc_ready & |fl.alloc_req & ~flush_w;
   assign fl.free_count   = count_q;
   assign fl.overflow_err = ovf_q;

   always_comb begin
      nalloc  = fire ? int'(nreq) : 0;
      room    = DEPTH - int'(count_q) + nalloc;
      entry_d = entry_q;
      nacc    = 0;
      for (int i = 0; i < FREE_WIDTH; i++)
         if (fl.free_en[i] && int'(f_pre[i]) < room) begin
            entry_d[ptr_add(int'(tail_q), int'(f_pre[i]))] = fl.free_reg[i];
            nacc = nacc + 1;
         end
      ovf_d   = ovf_q | (int'(nfree) > room);
      tail_d  = ptr_add(int'(tail_q), nacc);
      head_d  = ptr_add(int'(head_q), nalloc);
      count_d = CNT_W'(int'(count_q) - nalloc + nacc);
`ifdef FREELIST_CHECKPOINT_EN
      chead_d  = ptr_add(int'(chead_q), int'(fl.commit_alloc_num));
      ccount_d = CNT_W'(int'(ccount_q) - int'(fl.commit_alloc_num) + nacc);
      head_d   = fl.flush ? chead_d : head_d;
      count_d  = fl.flush ? ccount_d : count_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            entry_q[i] <= PREG_W'(ARCH_REGS + i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(DEPTH);
         ovf_q   <= 1'b0;
`ifdef FREELIST_CHECKPOINT_EN
         chead_q  <= '0;
         ccount_q <= CNT_W'(DEPTH);
`endif
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
`ifdef FREELIST_CHECKPOINT_EN
         chead_q  <= chead_d;
         ccount_q <= ccount_d;
`endif
      end
   end
endmodule

// File: tb/tb_unified_freelist.sv
// tb_unified_freelist: directed vectors with hand-computed expectations for unified_freelist
module tb_unified_freelist;
   import unified_freelist_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   unified_freelist_if fl ();
   unified_freelist dut (.clk(clk), .rst(rst), .fl(fl));

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fl.alloc_req = '0;
      fl.free_en   = '0;
      fl.free_reg  = '0;
`ifdef FREELIST_CHECKPOINT_EN
      fl.flush            = 1'b0;
      fl.commit_alloc_num = '0;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      do_reset();
      #1;
      check("reset_count", int'(fl.free_count), 32);
      check("reset_ovf", int'(fl.overflow_err), 0);
      check("idle_ready", int'(fl.alloc_ready), 1);

      fl.alloc_req = 2'b11;
      #1;
      check("dual_ready", int'(fl.alloc_ready), 1);
      check("dual_lane0", int'(fl.alloc_reg[0]), 32);
      check("dual_lane1", int'(fl.alloc_reg[1]), 33);
      tick();
      idle();
      #1;
      check("dual_count", int'(fl.free_count), 30);

      // reset mid-operation restores the full pool
      do_reset();
      fl.alloc_req = 2'b10;
      #1;
      check("reset_mid_count", int'(fl.free_count), 32);
      check("compact_lane1", int'(fl.alloc_reg[1]), 32);
      check("compact_lane0", int'(fl.alloc_reg[0]), 32);
      tick();
      fl.alloc_req = 2'b01;
      #1;
      check("compact_count", int'(fl.free_count), 31);
      check("compact_head", int'(fl.alloc_reg[0]), 33);
      tick();
      fl.alloc_req = 2'b11;
      for (int i = 0; i < 14; i++) tick();
      fl.alloc_req = 2'b01;
      tick();
      idle();
      #1;
      check("drain_count", int'(fl.free_count), 1);

      fl.alloc_req   = 2'b11;
      fl.free_en     = 2'b01;
      fl.free_reg[0] = 6'd40;
      #1;
      check("short_ready", int'(fl.alloc_ready), 0);
      tick();
      idle();
      fl.alloc_req = 2'b11;
      #1;
      check("short_count", int'(fl.free_count), 2);
      check("wrap_ready", int'(fl.alloc_ready), 1);
      check("wrap_lane0", int'(fl.alloc_reg[0]), 63);
      check("wrap_lane1", int'(fl.alloc_reg[1]), 40);
      tick();
      fl.alloc_req = 2'b01;
      #1;
      check("empty_count", int'(fl.free_count), 0);
      check("empty_ready_req", int'(fl.alloc_ready), 0);
      fl.alloc_req = 2'b00;
      #1;
      check("empty_ready_idle", int'(fl.alloc_ready), 1);

      fl.free_en     = 2'b11;
      fl.free_reg[0] = 6'd7;
      fl.free_reg[1] = 6'd9;
      tick();
      idle();
      fl.alloc_req = 2'b11;
      #1;
      check("fifo_count", int'(fl.free_count), 2);
      check("fifo_lane0", int'(fl.alloc_reg[0]), 7);
      check("fifo_lane1", int'(fl.alloc_reg[1]), 9);
      tick();
      idle();
      fl.free_en     = 2'b10;
      fl.free_reg[0] = 6'd50;
      fl.free_reg[1] = 6'd12;
      tick();
      idle();
      fl.alloc_req = 2'b01;
      #1;
      check("free_compact_count", int'(fl.free_count), 1);
      check("free_compact_reg", int'(fl.alloc_reg[0]), 12);
      check("no_ovf", int'(fl.overflow_err), 0);

      do_reset();
      fl.free_en     = 2'b01;
      fl.free_reg[0] = 6'd5;
      tick();
      idle();
      #1;
      check("ovf_set", int'(fl.overflow_err), 1);
      check("ovf_count", int'(fl.free_count), 32);
      tick();
      fl.alloc_req = 2'b01;
      #1;
      check("ovf_sticky", int'(fl.overflow_err), 1);
      check("ovf_no_write", int'(fl.alloc_reg[0]), 32);
      do_reset();
      #1;
      check("ovf_cleared", int'(fl.overflow_err), 0);

`ifdef FREELIST_CHECKPOINT_EN
      fl.alloc_req = 2'b11;
      tick();
      tick();
      idle();
      fl.commit_alloc_num = 2'd1;
      fl.flush            = 1'b1;
      fl.alloc_req        = 2'b11;
      tick();
      idle();
      fl.alloc_req = 2'b01;
      #1;
      check("flush_count", int'(fl.free_count), 31);
      check("flush_grant", int'(fl.alloc_reg[0]), 33);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
